// File: rtl/seq_barrel_shifter.sv
// Sequential barrel shifter: one binary-weighted stage (1, 2, 4, ... WIDTH/2) per clock.
// Logical or arithmetic shifts, left or right, by 0..WIDTH-1. The latency is always SHW+1
// cycles from start to done, whatever the shift amount.
// Optional feature: define SEQ_SHIFTER_ROTATE_EN to add a 'rotate' input that turns every stage
// into a circular rotate.
module seq_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  input  logic             direction,
  input  logic             aritmetic_logic,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [SHW-1:0] LastStage = SHW'(SHW - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   shamt_q;
  logic [SHW-1:0]   k_q;
  logic             dir_q;      // 1 = left
  logic             logical_q;  // 1 = zero fill on right shifts
  logic             sign_q;     // operand MSB, constant for the whole operation
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             rot_en;

  logic             accept;
  logic             last_stage;
  logic [SHW-1:0]   step;
  logic [SHW:0]     back;
  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] stage_out;

  // A start is taken in IDLE and also in DONE, which gives back-to-back operation
  assign accept     = start && (state_q != StShift);
  assign last_stage = (state_q == StShift) && (k_q == LastStage);

`ifdef SEQ_SHIFTER_ROTATE_EN
  logic rot_q;

  // Rotate mode is captured with the other controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot_q <= 1'b0;
    end else if (accept) begin
      rot_q <= rotate;
    end
  end

  assign rot_en = rot_q;
`else
  assign rot_en = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (last_stage) state_d = StDone;
      StDone:  state_d = accept ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StShift: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // One shift stage: move by 2^k when shamt bit k is set, otherwise pass through
  always_comb begin
    step      = SHW'(1) << k_q;
    // Complementary distance that brings the shifted-out bits back in for rotates
    back      = (SHW + 1)'(WIDTH) - {1'b0, step};
    fill_mask = ~({WIDTH{1'b1}} >> step);
    shl       = work_q << step;
    shr       = work_q >> step;
    stage_out = work_q;
    if (shamt_q[k_q]) begin
      if (dir_q) begin
        stage_out = rot_en ? (shl | (work_q >> back)) : shl;
      end else if (rot_en) begin
        stage_out = shr | (work_q << back);
      end else if (logical_q) begin
        stage_out = shr;
      end else begin
        stage_out = shr | (sign_q ? fill_mask : '0);
      end
    end
  end

  // Capture on accept, then run one stage per edge; the last stage also writes the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q    <= '0;
      shamt_q   <= '0;
      k_q       <= '0;
      dir_q     <= 1'b0;
      logical_q <= 1'b0;
      sign_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else if (accept) begin
      work_q    <= operand;
      shamt_q   <= shamt;
      k_q       <= '0;
      dir_q     <= direction;
      logical_q <= aritmetic_logic;
      sign_q    <= operand[WIDTH-1];
    end else if (state_q == StShift) begin
      work_q <= stage_out;
      k_q    <= k_q + SHW'(1);
      if (last_stage) begin
        result_q <= stage_out;
        zero_q   <= ~|stage_out;
      end
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Scoreboard bench for seq_barrel_shifter: the driver pushes expected results with their due
// cycle, and a monitor pops and compares on every done pulse.
module tb_seq_barrel_shifter;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   shamt;
  logic             direction;
  logic             aritmetic_logic;
  logic             rotate;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             zero;

  seq_barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .operand         (operand),
    .shamt           (shamt),
    .direction       (direction),
    .aritmetic_logic (aritmetic_logic),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rotate          (rotate),
`endif
    .result          (result),
    .busy            (busy),
    .done            (done),
    .zero            (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               due;
  } exp_t;

  exp_t             sb[$];
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] held = '0;
  bit               mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain shift operators on the whole word
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] op, input int sh,
                                             input bit dir, input bit al, input bit rot);
    if (rot) return dir ? ((op << sh) | (op >> (WIDTH - sh))) : ((op >> sh) | (op << (WIDTH - sh)));
    if (dir) return op << sh;
    if (al) return op >> sh;
    return $signed(op) >>> sh;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on done, otherwise the result must hold its last value
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got result %h with no operation pending", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", result, e.res);
          check("zero", {31'b0, zero}, {31'b0, e.res == '0});
          check("latency", cyc, e.due);
          check("busy_in_done", {31'b0, busy}, '0);
          held = e.res;
        end
      end else begin
        check("hold", result, held);
      end
    end
  end

  // Issue one operation at a negedge once the shifter is free
  task automatic issue(input logic [WIDTH-1:0] op, input int sh, input bit dir, input bit al,
                       input bit rot, input bit expect_done);
    int guard = 0;
    exp_t e;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: got busy=1 expected busy=0 within 100 cycles");
    end
    operand         = op;
    shamt           = SHW'(sh);
    direction       = dir;
    aritmetic_logic = al;
    rotate          = rot;
    start           = 1'b1;
    if (expect_done) begin
      e.res = model(op, sh, dir, al, rot);
      e.due = cyc + 1 + SHW;
      sb.push_back(e);
    end
    @(negedge clk);
    start           = 1'b0;
    // Inputs may change freely once captured
    operand         = $urandom;
    shamt           = SHW'($urandom);
    direction       = $urandom_range(0, 1);
    aritmetic_logic = $urandom_range(0, 1);
    rotate          = $urandom_range(0, 1);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    start = 1'b0;
    operand = '0;
    shamt = '0;
    direction = 1'b0;
    aritmetic_logic = 1'b0;
    rotate = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", result, '0);
    check("reset_zero", {31'b0, zero}, 32'd1);
    check("reset_busy", {31'b0, busy}, '0);
    check("reset_done", {31'b0, done}, '0);
    reset = 1'b0;
    held = '0;
    mon_en = 1'b1;
    @(negedge clk);

    // Reset in the middle of SHIFT aborts without a done pulse
    issue(32'hFFFF_0000, 16, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, '0);
    check("abort_done", {31'b0, done}, '0);
    check("abort_result", result, '0);
    check("abort_zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    held = '0;
    repeat (SHW + 3) @(negedge clk);

    // Directed cases
    issue(32'h8000_F00F, 16, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(32'h8000_F00F, 31, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h7FFF_FFFF, 31, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h0000_0001, 31, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h1234_5678, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h8765_4321, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    // A start while busy must be ignored
    issue(32'hDEAD_BEEF, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    operand = 32'h0000_0000;
    shamt = 5'd1;
    direction = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

`ifdef SEQ_SHIFTER_ROTATE_EN
    issue(32'h0000_00F1, 4, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(32'h0000_00F1, 4, 1'b1, 1'b0, 1'b1, 1'b1);
`endif

    // Randomized traffic, mostly back-to-back (issue lands in the DONE cycle)
    for (int i = 0; i < 150; i++) begin
      bit rot;
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot = $urandom_range(0, 1);
`else
      rot = 1'b0;
`endif
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue($urandom, $urandom_range(0, WIDTH - 1), $urandom_range(0, 1),
            $urandom_range(0, 1), rot, 1'b1);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
